// File: rtl/cpu_sram_bridge.sv
// cpu_sram_bridge: stalls a single-cycle core data port over a split addr/data-phase bus.
// Optional abort watchdog enabled by defining CPU_SRAM_BRIDGE_TIMEOUT_EN.
`default_nettype none

module cpu_sram_bridge #(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic        clock,
    input  logic        reset_,
    input  logic        data_ram_enabled,
    input  logic [3:0]  data_ram_write_enabled,
    input  logic [31:0] data_ram_address,
    input  logic [31:0] data_ram_write_data,
    output logic [31:0] data_ram_read_data,
    output logic        data_ram_stall,
    output logic        bus_req,
    output logic        bus_wr,
    output logic [3:0]  bus_strobe,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic        bus_addr_ok,
    input  logic        bus_data_ok,
    input  logic [31:0] bus_rdata,
    output logic        bus_timeout
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  strb_q, strb_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        is_read;
    logic        timeout_hit;

    assign is_read = (strb_q == 4'b0000);

`ifdef CPU_SRAM_BRIDGE_TIMEOUT_EN
    logic [15:0] cnt_q, cnt_d;
    logic        tmo_q, tmo_d;

    // Counter is zero in the first ADDR cycle and counts every cycle spent on the bus.
    always_comb begin
        cnt_d = cnt_q;
        if (state_q == S_IDLE && data_ram_enabled) begin
            cnt_d = 16'd0;
        end else if (state_q == S_ADDR || state_q == S_DATA) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    assign timeout_hit = (cnt_q == 16'(TIMEOUT_CYCLES - 1));
    assign bus_timeout = tmo_q;

    always_ff @(posedge clock or negedge reset_) begin
        if (!reset_) begin
            cnt_q <= 16'd0;
            tmo_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            tmo_q <= tmo_d;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign bus_timeout = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        strb_d  = strb_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
`ifdef CPU_SRAM_BRIDGE_TIMEOUT_EN
        tmo_d   = tmo_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (data_ram_enabled) begin
                    addr_d  = data_ram_address;
                    strb_d  = data_ram_write_enabled;
                    wdata_d = data_ram_write_data;
                    state_d = S_ADDR;
                end
            end
            S_ADDR: begin
                // Completion is tested before the watchdog so a coincident finish wins.
                if (bus_addr_ok && bus_data_ok) begin
                    state_d = S_DONE;
                    if (is_read) rdata_d = bus_rdata;
                end else if (timeout_hit) begin
                    state_d = S_DONE;
                    rdata_d = 32'hDEAD_BEEF;
`ifdef CPU_SRAM_BRIDGE_TIMEOUT_EN
                    tmo_d   = 1'b1;
`endif
                end else if (bus_addr_ok) begin
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (bus_data_ok) begin
                    state_d = S_DONE;
                    if (is_read) rdata_d = bus_rdata;
                end else if (timeout_hit) begin
                    state_d = S_DONE;
                    rdata_d = 32'hDEAD_BEEF;
`ifdef CPU_SRAM_BRIDGE_TIMEOUT_EN
                    tmo_d   = 1'b1;
`endif
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_) begin
        if (!reset_) begin
            state_q <= S_IDLE;
            addr_q  <= 32'd0;
            strb_q  <= 4'd0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            strb_q  <= strb_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    // The latched request registers drive the bus directly, so fields cannot move mid-phase.
    assign bus_req            = (state_q == S_ADDR);
    assign bus_wr             = |strb_q;
    assign bus_strobe         = strb_q;
    assign bus_addr           = addr_q;
    assign bus_wdata          = wdata_q;
    assign data_ram_read_data = rdata_q;
    assign data_ram_stall     = (state_q == S_ADDR) | (state_q == S_DATA) |
                                ((state_q == S_IDLE) & data_ram_enabled);

endmodule

`default_nettype wire

// File: tb/tb_cpu_sram_bridge.sv
// tb_cpu_sram_bridge: table vectors, randomized transfers against a transaction-level model,
// plus reset-abort and (optionally) watchdog sequences.
`default_nettype none

module tb_cpu_sram_bridge;

    logic        clock;
    logic        reset_;
    logic        en;
    logic [3:0]  we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rd_data;
    logic        stall;
    logic        bus_req;
    logic        bus_wr;
    logic [3:0]  bus_strobe;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] bus_rdata;
    logic        bus_timeout;

    int n_pass  = 0;
    int n_total = 0;
    logic [31:0] last_rd;

    cpu_sram_bridge #(.TIMEOUT_CYCLES(16)) dut (
        .clock                 (clock),
        .reset_                (reset_),
        .data_ram_enabled      (en),
        .data_ram_write_enabled(we),
        .data_ram_address      (addr),
        .data_ram_write_data   (wdata),
        .data_ram_read_data    (rd_data),
        .data_ram_stall        (stall),
        .bus_req               (bus_req),
        .bus_wr                (bus_wr),
        .bus_strobe            (bus_strobe),
        .bus_addr              (bus_addr),
        .bus_wdata             (bus_wdata),
        .bus_addr_ok           (addr_ok),
        .bus_data_ok           (data_ok),
        .bus_rdata             (bus_rdata),
        .bus_timeout           (bus_timeout)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] a;
        logic [3:0]  s;
        logic [31:0] wd;
        int          ad;
        int          dd;
        logic [31:0] rd;
        int          exp_stall;
        logic [31:0] exp_rd;
    } vec_t;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Core issues one request (starting from IDLE) and the bench plays the bus slave:
    // addr_ok after ad waiting cycles (ad<0: never), data_ok dd cycles later (0: same cycle).
    task automatic xfer(input logic [31:0] a, input logic [3:0] s, input logic [31:0] wd,
                        input int ad, input int dd, input logic [31:0] rd,
                        output int stall_n, output logic [31:0] rd_out);
        int  aw = 0;
        int  dw = 0;
        int  cyc = 0;
        bit  in_data = 0;
        bit  done = 0;
        stall_n = 0;
        @(negedge clock);
        en = 1'b1; we = s; addr = a; wdata = wd;
        addr_ok = 1'b0; data_ok = 1'($urandom % 2); bus_rdata = $urandom;
        #1;
        chk("idle_before_req", bus_req, 1'b0);
        if (stall) stall_n++;
        while (!done && cyc < 200) begin
            @(negedge clock);
            cyc++;
            addr_ok = 1'b0; data_ok = 1'b0; bus_rdata = $urandom;
            if (bus_req) begin
                chk("bus_fields", {bus_wr, bus_strobe, bus_addr, bus_wdata}, {|s, s, a, wd});
                if (ad >= 0 && aw == ad) begin
                    addr_ok = 1'b1;
                    if (dd == 0) begin
                        data_ok = 1'b1; bus_rdata = rd;
                    end else begin
                        in_data = 1;
                    end
                end
                aw++;
            end else if (in_data) begin
                dw++;
                if (dw == dd) begin
                    data_ok = 1'b1; bus_rdata = rd; in_data = 0;
                end
            end else begin
                data_ok = 1'($urandom % 2);
            end
            #1;
            if (!stall) done = 1;
            else stall_n++;
        end
        if (!done) chk("xfer_wait_bound", 1'b0, 1'b1);
        rd_out = rd_data;
    endtask

    task automatic idle_cycle();
        @(negedge clock);
        en = 1'b0; addr_ok = 1'($urandom % 2); data_ok = 1'($urandom % 2);
        #1;
        chk("idle_stall", stall, 1'b0);
        chk("idle_req", bus_req, 1'b0);
    endtask

    initial begin
        vec_t        tbl[6];
        int          sn;
        logic [31:0] ro;

        tbl[0] = '{32'h1000, 4'b0000, 32'h0,        1,  2, 32'h1234_5678, 5,  32'h1234_5678};
        tbl[1] = '{32'h2004, 4'b0011, 32'hAABBCCDD, 0,  0, 32'h0BAD_0BAD, 2,  32'h1234_5678};
        tbl[2] = '{32'h3000, 4'b0000, 32'h0,        0,  0, 32'hCAFE_F00D, 2,  32'hCAFE_F00D};
        tbl[3] = '{32'h4008, 4'b0000, 32'h0,        10, 1, 32'h00C0_FFEE, 13, 32'h00C0_FFEE};
        tbl[4] = '{32'h500C, 4'b1111, 32'h01020304, 2,  3, 32'h5555_AAAA, 7,  32'h00C0_FFEE};
        tbl[5] = '{32'h6000, 4'b0000, 32'h0,        0,  1, 32'h1111_2222, 3,  32'h1111_2222};

        reset_ = 1'b0; en = 1'b1; we = 4'd0; addr = 32'd0; wdata = 32'd0;
        addr_ok = 1'b0; data_ok = 1'b0; bus_rdata = 32'd0;
        #3;
        chk("rst_stall_en1", stall, 1'b1);
        chk("rst_outputs", {bus_req, bus_wr, bus_strobe, bus_addr, bus_wdata, rd_data, bus_timeout}, '0);
        en = 1'b0;
        #1;
        chk("rst_stall_en0", stall, 1'b0);
        repeat (2) @(negedge clock);
        reset_ = 1'b1;
        last_rd = 32'd0;

        // Directed table; entries 0..5 run back to back with enabled held through DONE.
        for (int i = 0; i < 6; i++) begin
            xfer(tbl[i].a, tbl[i].s, tbl[i].wd, tbl[i].ad, tbl[i].dd, tbl[i].rd, sn, ro);
            chk($sformatf("tbl%0d_stall_cycles", i), sn, tbl[i].exp_stall);
            chk($sformatf("tbl%0d_read_data", i), ro, tbl[i].exp_rd);
        end
        last_rd = tbl[5].exp_rd;
        idle_cycle();

        // Randomized transfers against the transaction model.
        for (int i = 0; i < 40; i++) begin
            logic [31:0] a  = $urandom & 32'hFFFF_FFFC;
            logic [3:0]  s  = ($urandom % 2) ? 4'($urandom) : 4'b0000;
            logic [31:0] wd = $urandom;
            int          ad = $urandom_range(0, 4);
            int          dd = $urandom_range(0, 3);
            logic [31:0] rd = $urandom;
            xfer(a, s, wd, ad, dd, rd, sn, ro);
            if (s == 4'b0000) last_rd = rd;
            chk("rand_stall_cycles", sn, 2 + ad + dd);
            chk("rand_read_data", ro, last_rd);
            if ($urandom % 3 == 0) idle_cycle();
        end

        // Reset while in DATA, then a stray data_ok after release.
        @(negedge clock);
        en = 1'b1; we = 4'b0000; addr = 32'h7000; addr_ok = 1'b0; data_ok = 1'b0;
        @(negedge clock);
        addr_ok = 1'b1;
        @(negedge clock);
        addr_ok = 1'b0;
        #1;
        chk("pre_reset_in_data", {bus_req, stall}, 2'b01);
        #1;
        reset_ = 1'b0;
        #1;
        chk("async_reset_outputs", {bus_req, bus_wr, bus_strobe, bus_addr, bus_wdata, rd_data}, '0);
        chk("async_reset_stall_en1", stall, 1'b1);
        en = 1'b0;
        #1;
        chk("async_reset_stall_en0", stall, 1'b0);
        @(negedge clock);
        reset_ = 1'b1;
        @(negedge clock);
        data_ok = 1'b1; bus_rdata = 32'hBAD0_0001;
        #1;
        chk("stray_data_ok_state", {bus_req, stall}, 2'b00);
        @(negedge clock);
        data_ok = 1'b0;
        #1;
        chk("stray_data_ok_rdata", rd_data, 32'd0);
        last_rd = 32'd0;

        xfer(32'h8000, 4'b0000, 32'h0, 1, 1, 32'h8765_4321, sn, ro);
        chk("post_reset_stall_cycles", sn, 4);
        chk("post_reset_read_data", ro, 32'h8765_4321);
        idle_cycle();

`ifdef CPU_SRAM_BRIDGE_TIMEOUT_EN
        // Completion on the last allowed cycle beats the watchdog.
        xfer(32'h9000, 4'b0000, 32'h0, 15, 0, 32'h7777_0000, sn, ro);
        chk("tmo_coincide_stall", sn, 17);
        chk("tmo_coincide_rdata", ro, 32'h7777_0000);
        chk("tmo_coincide_flag", bus_timeout, 1'b0);
        xfer(32'hA000, 4'b0000, 32'h0, -1, 0, 32'h0, sn, ro);
        chk("tmo_abort_stall", sn, 17);
        chk("tmo_abort_rdata", ro, 32'hDEAD_BEEF);
        chk("tmo_abort_flag", bus_timeout, 1'b1);
        chk("tmo_abort_req", bus_req, 1'b0);
        xfer(32'hB000, 4'b0000, 32'h0, 0, 1, 32'h4242_4242, sn, ro);
        chk("tmo_after_rdata", ro, 32'h4242_4242);
        chk("tmo_flag_held", bus_timeout, 1'b1);
        @(negedge clock);
        reset_ = 1'b0;
        #1;
        chk("tmo_flag_reset", bus_timeout, 1'b0);
        @(negedge clock);
        reset_ = 1'b1;
`else
        chk("timeout_tied_low", bus_timeout, 1'b0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
